// File: rtl/spi_slave_link.sv
// Mode-0 SPI slave bridging an external master to RX/TX byte fifos, oversampled in the clk domain.
// Define SPI_SLAVE_LINK_TX_EN to build the MISO path; otherwise the block is receive-only.
module spi_slave_link #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_write_enable,
    input  logic                  rx_fifo_full,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_fifo_empty,
    output logic                  tx_read_enable,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    input  logic                  status_clear
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_d, cs_d;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, select, deselect;

    logic [1:0]             state;
    logic [CW-1:0]          bit_count;
    logic [DATA_WIDTH-1:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  rx_next;
    logic                   word_done;
    logic                   tx_load;

    // Chains idle at the deselected bus state so reset release never looks like a select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign select   = ~cs_s & cs_d;
    assign deselect = cs_s & ~cs_d;

    assign rx_next   = {rx_shift[DATA_WIDTH-2:0], mosi_s};
    assign word_done = (state == SHIFT) && !deselect && sck_rise &&
                       (bit_count == CW'(DATA_WIDTH - 1));
    assign tx_load   = ((state == LOAD) && !deselect) || word_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            bit_count       <= '0;
            rx_shift        <= '0;
            rx_data         <= '0;
            rx_write_enable <= 1'b0;
            rx_overrun      <= 1'b0;
        end else begin
            rx_write_enable <= 1'b0;
            if (deselect) begin
                state     <= IDLE;
                bit_count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        bit_count <= '0;
                        if (select)
                            state <= LOAD;
                    end
                    LOAD: state <= SHIFT;
                    SHIFT: begin
                        if (sck_rise) begin
                            rx_shift <= rx_next;
                            if (word_done) begin
                                rx_data         <= rx_next;
                                bit_count       <= '0;
                                rx_write_enable <= !rx_fifo_full;
                            end else begin
                                bit_count <= bit_count + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (word_done && rx_fifo_full)
                rx_overrun <= 1'b1;
            else if (status_clear)
                rx_overrun <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_LINK_TX_EN
    logic [DATA_WIDTH-1:0] tx_shift;

    // The fall right after a load (bit_count 0) is skipped so the MSB meets the first rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift       <= '0;
            tx_read_enable <= 1'b0;
            tx_underrun    <= 1'b0;
        end else begin
            tx_read_enable <= 1'b0;
            if (state == IDLE || deselect) begin
                tx_shift <= '0;
            end else if (tx_load) begin
                if (!tx_fifo_empty) begin
                    tx_shift       <= tx_data;
                    tx_read_enable <= 1'b1;
                end else begin
                    tx_shift <= '0;
                end
            end else if (state == SHIFT && sck_fall && bit_count != '0) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end

            if (tx_load && tx_fifo_empty)
                tx_underrun <= 1'b1;
            else if (status_clear)
                tx_underrun <= 1'b0;
        end
    end

    assign miso = (state != IDLE) & tx_shift[DATA_WIDTH-1];
`else
    logic unused_tx;

    assign unused_tx      = ^{tx_data, tx_fifo_empty, tx_load};
    assign miso           = 1'b0;
    assign tx_read_enable = 1'b0;
    assign tx_underrun    = 1'b0;
`endif

endmodule

// File: doc/spi_slave_link.md
# spi_slave_link

Mode-0 SPI slave that bridges an external SPI master to a pair of `fifo` instances. It oversamples `sck`, `cs_n` and `mosi` in the system clock domain and deserializes MOSI bytes into single-cycle pushes to the RX fifo. It also pops bytes from the TX fifo and serializes them onto MISO. It sits directly upstream of the RX fifo's `data_input`/`write_enable` and directly downstream of the TX fifo's `data_output`/`read_enable`.

## Interface
- `DATA_WIDTH`, default 8: bits per SPI transfer word; matches the fifo `DATA_WIDTH`.
- `SYNC_STAGES`, default 2: synchronizer flops on `sck`, `cs_n`, `mosi`; legal values are 2 or more.
- `clk` input, 1 bit: system clock; all logic on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `sck` input, 1 bit: SPI clock from the master; asynchronous to `clk`; idle low.
- `cs_n` input, 1 bit: chip select, active low; asynchronous.
- `mosi` input, 1 bit: master-out data.
- `miso` output, 1 bit: slave-out data; driven 0 while deselected.
- `rx_data` output, DATA_WIDTH bits: last completed MOSI word.
- `rx_write_enable` output, 1 bit: one-cycle push to the RX fifo.
- `rx_fifo_full` input, 1 bit: RX fifo `fifo_full`.
- `tx_data` input, DATA_WIDTH bits: TX fifo `data_output` (combinational read).
- `tx_fifo_empty` input, 1 bit: TX fifo `fifo_empty`.
- `tx_read_enable` output, 1 bit: one-cycle pop of the TX fifo.
- `rx_overrun` output, 1 bit: sticky; a word was dropped because the RX fifo was full.
- `tx_underrun` output, 1 bit: sticky; 0 was sent because the TX fifo was empty.
- `status_clear` input, 1 bit: synchronous clear of both sticky flags.

## Operation
- Synchronizer chains reset to `sck`=0, `cs_n`=1, `mosi`=0.
- One extra flop on synced `sck` and `cs_n` gives the edge detectors: rise, fall, select, deselect.
- State machine:
  - IDLE: `miso`=0, `bit_count`=0. On a select (synced `cs_n` 1→0) go to LOAD.
  - LOAD: exactly one cycle. Load the TX shift register, then go to SHIFT.
  - SHIFT: handles `sck` edges as below. A deselect in any state returns to IDLE.
- TX load, in LOAD or on word completion:
  - If `tx_fifo_empty`=0: shift register ← `tx_data` and pulse `tx_read_enable`.
  - If `tx_fifo_empty`=1: shift register ← 0 and set `tx_underrun`; no pop.
- `miso` is the shift register MSB while in SHIFT or LOAD.
- `sck` rise in SHIFT:
  - RX shift ← {RX shift[DATA_WIDTH-2:0], synced `mosi`}; `bit_count` increments.
  - When `bit_count` reaches DATA_WIDTH, the word completes: `rx_data` ← the assembled word and `bit_count` ← 0. Then either push (pulse `rx_write_enable`) or, if `rx_fifo_full`=1, drop (no pulse, set `rx_overrun`). A TX load happens in the same cycle.
- `sck` fall in SHIFT: TX shift left by one, but only when `bit_count` is not 0. The falling edge right after a load is ignored, so the MSB is held for the first rising edge.
- Deselect mid-word: the partial RX word is discarded with no push. The popped TX word is lost. `bit_count` ← 0.
- `status_clear` clears both sticky flags. If `status_clear` and a set condition occur in the same cycle, set wins.

## Timing
- Reset values: `miso`=0, `rx_data`=0, `rx_write_enable`=0, `tx_read_enable`=0, `rx_overrun`=0, `tx_underrun`=0. State is IDLE.
- Edge detect latency: SYNC_STAGES+1 `clk` cycles from a pin transition.
- `rx_write_enable` pulses one cycle, SYNC_STAGES+2 cycles after the last `sck` rise of a word. `rx_data` is valid in that cycle and holds until the next completion.
- `tx_read_enable` pulses in the same cycle as the load; the fifo advances its read address at the next `clk` edge.
- `miso` valid SYNC_STAGES+2 cycles after a select or an `sck` fall.
- Master constraint: `sck` high and low phases each ≥ SYNC_STAGES+3 `clk` periods. `cs_n` setup before the first `sck` rise is also ≥ SYNC_STAGES+3 `clk` periods.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs at reset values. No partial push.

## Configuration
- `SPI_SLAVE_LINK_TX_EN` defined: MISO path present, as described above.
- Undefined:
  - No TX shift register.
  - `miso` tied 0, `tx_read_enable` tied 0, `tx_underrun` tied 0.
  - `tx_data` and `tx_fifo_empty` ignored.
  - RX behaviour identical.

## Test plan
- Reset then idle: all outputs 0; toggling `sck` with `cs_n`=1 gives no pulses.
- Select, send MOSI 0xA5: exactly one `rx_write_enable` pulse with `rx_data`=0xA5, SYNC_STAGES+2 cycles after the 8th `sck` rise.
- TX fifo holding 0x3C, 0xC3; two-word transfer: MISO bits read 0x3C then 0xC3; exactly two `tx_read_enable` pulses.
- `rx_fifo_full`=1 during a 0x7E transfer: no push, `rx_overrun`=1; pulse `status_clear` → `rx_overrun`=0.
- `tx_fifo_empty`=1 at select: MISO shifts 0x00 and `tx_underrun`=1. `cs_n` raised after 5 bits: no `rx_write_enable`; the next full word 0x81 is received cleanly.
- `reset` asserted after 4 bits: outputs return to 0. The next transfer of 0x55 pushes 0x55.
